sec_countdown: RTL

- Programmable seconds countdown that consumes the 1 Hz output of the one-second timer stage.
- Runs on the 240 Hz system clock.
- Edge-detects the 1 Hz square wave and decrements a loaded duration once per second.
- Signals expiry to downstream game/control logic, e.g. the 4-second action window.

---
 rtl/sec_countdown_pkg.sv | 22 ++
 rtl/sec_countdown_rise_detect.sv | 30 +++
 rtl/sec_countdown.sv | 118 +++++++++++
 3 files changed

// File: rtl/sec_countdown_pkg.sv
// ============================================================================
// Module  : sec_countdown_pkg
// Brief   : Shared constants and state encoding for the seconds countdown.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sec_countdown_pkg;

    localparam int SYS_HZ       = 240;
    localparam int DEFAULT_SECS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sec_countdown_rise_detect.sv
// ============================================================================
// Module  : rise_detect
// Brief   : Single-cycle pulse on each rising edge of a slow input level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_in_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    // Combinational so the pulse lands on the cycle the new level is sampled.
    assign pulse = in & ~r_in_q;

endmodule

`default_nettype wire

// File: rtl/sec_countdown.sv
// ============================================================================
// Module  : sec_countdown
// Brief   : Loadable seconds countdown driven by the 1 Hz square wave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_countdown
    import sec_countdown_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_SECS = sec_countdown_pkg::DEFAULT_SECS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam logic [WIDTH-1:0] C_RESET_SECS = WIDTH'(DEFAULT_SECS);
    localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);

    logic             w_sec_tick;
    state_t           r_state;
    logic [WIDTH-1:0] r_remaining;
    logic             r_running;
    logic             r_done;
    logic             r_expired;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .in    (sec_in),
        .pulse (w_sec_tick)
    );

    // Strobe priority is load > pause > start > tick; each branch is exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= C_RESET_SECS;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_remaining <= load_value;
                    end else if (start && !pause) begin
                        if (r_remaining != '0) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state   <= ST_EXPIRED;
                            r_expired <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        r_remaining <= load_value;
                    end else if (pause) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end else if ((r_remaining == '0) ||
                                 (w_sec_tick && r_remaining == C_ONE)) begin
                        // A zero count left by a mid-run load expires here too.
                        r_remaining <= '0;
                        r_state     <= ST_EXPIRED;
                        r_running   <= 1'b0;
                        r_expired   <= 1'b1;
                        r_done      <= 1'b1;
                    end else if (w_sec_tick) begin
                        r_remaining <= r_remaining - C_ONE;
                    end
                end
                ST_PAUSED: begin
                    if (load) begin
                        r_remaining <= load_value;
                    end else if (start && !pause) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (load) begin
                        r_remaining <= load_value;
                        r_state     <= ST_IDLE;
                        r_expired   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_expired <= 1'b0;
                end
            endcase
        end
    end

    assign remaining = r_remaining;
    assign running   = r_running;
    assign done      = r_done;
    assign expired   = r_expired;

endmodule

`default_nettype wire
